// File: rtl/seven_seg_pkg.sv
// Shared definitions for the score seven-segment display.
//   seg_t         : segment vector, bit7=a .. bit1=g, bit0=h (decimal point)
//   SEG_DIGIT     : segment patterns for decimal digits 0..9 (active-high)
//   SEG_BLANK     : all segments off
//   conv_state_e  : binary-to-BCD converter state
//   seg_of()      : digit -> segment pattern, non-decimal nibbles blank
//   pow10()       : elaboration-time helper for the digit-count check
package seven_seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'h00;

  localparam seg_t SEG_DIGIT [0:9] = '{
    8'b1111_1100, 8'b0110_0000, 8'b1101_1010, 8'b1111_0010, 8'b0110_0110,
    8'b1011_0110, 8'b1011_1110, 8'b1110_0000, 8'b1111_1110, 8'b1111_0110
  };

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  function automatic seg_t seg_of(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/score_seven_seg_display_bcd.sv
// bin_to_bcd_seq: serial double-dabble binary-to-BCD converter.
//   clk, rst  : clock, synchronous active-high reset
//   i_start   : accepted only in IDLE; latches i_value and begins conversion
//   i_value   : binary value to convert (W bits)
//   o_busy    : high in SHIFT and DONE
//   o_done    : high for the single DONE cycle; o_bcd is valid then
//   o_bcd     : N BCD digits, digit 0 in bits [3:0]
//   o_state   : current converter state (debug)
// Handshake: i_start is a one-cycle request, honoured only while o_busy is low;
// the result is handed over during the cycle o_done is high.
module bin_to_bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_value,
  output logic           o_busy,
  output logic           o_done,
  output logic [4*N-1:0] o_bcd,
  output conv_state_e    o_state
);

  localparam int CW = $clog2(W + 1);

  conv_state_e    r_state;
  logic [W-1:0]   r_shift;
  logic [4*N-1:0] r_bcd;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [4*N-1:0] w_adj;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    w_adj = r_bcd;
    for (int n = 0; n < N; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CONV_IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        CONV_IDLE: begin
          if (i_start) begin
            r_shift <= i_value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) begin
            r_done  <= 1'b1;
            r_state <= CONV_DONE;
          end
        end
        CONV_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= CONV_IDLE;
        end
        default: r_state <= CONV_IDLE;
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_bcd   = r_bcd;
  assign o_state = r_state;

endmodule

// File: rtl/score_seven_seg_display.sv
// score_seven_seg_display: shows a binary score in decimal on a multiplexed
// seven-segment display with leading-zero blanking and tear-free updates.
//   clk       : system clock
//   rst       : synchronous reset, active-high
//   score     : unsigned score, sampled every clock
//   abcdefgh  : segments, active-high, bit0 (dp) always 0
//   digit     : one-hot digit enable, bits >= n_show always 0
//   busy      : converter running
// Optional feature macro: SEVEN_SEG_BLINK_EN -- blink the display for one
// second (8 phases of 125 ms, odd phases dark) after each displayed change.
module score_seven_seg_display
  import seven_seg_pkg::*;
#(
  parameter int clk_mhz  = 50,
  parameter int w_digit  = 8,
  parameter int w_score  = 8,
  parameter int n_show   = 3,
  parameter int scan_div = clk_mhz * 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [w_score-1:0] score,
  output logic [7:0]         abcdefgh,
  output logic [w_digit-1:0] digit,
  output logic               busy
);

  localparam int IDX_W  = (n_show > 1) ? $clog2(n_show) : 1;
  localparam int SCAN_W = (scan_div > 1) ? $clog2(scan_div) : 1;

  if (pow10(n_show) < (longint'(1) << w_score)) begin : g_bad_digits
    $error("n_show too small to hold every score value");
  end
  if (w_digit < n_show) begin : g_bad_width
    $error("w_digit narrower than n_show");
  end

  logic [w_score-1:0]  r_last_score;
  logic [4*n_show-1:0] r_shown;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [IDX_W-1:0]    r_idx;
  seg_t                r_seg;
  logic [w_digit-1:0]  r_digit;

  conv_state_e         w_state;
  logic                w_start;
  logic                w_done;
  logic [4*n_show-1:0] w_bcd;
  logic [3:0]          w_nib;
  logic                w_upper_nz;
  logic                w_blank;
  logic                w_force_off;

  // A new conversion is requested only while the converter is idle; any score
  // change during a conversion is picked up by the next idle comparison.
  assign w_start = (w_state == CONV_IDLE) && (score != r_last_score);

  bin_to_bcd_seq #(.W(w_score), .N(n_show)) u_conv (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_value (score),
    .o_busy  (busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd),
    .o_state (w_state)
  );

  // Blank the current digit when it and every more significant digit are zero;
  // digit 0 is never blanked so a zero score still shows "0".
  always_comb begin
    w_nib      = r_shown[4*r_idx +: 4];
    w_upper_nz = 1'b0;
    for (int n = 0; n < n_show; n++) begin
      if ((IDX_W'(n) >= r_idx) && (r_shown[4*n +: 4] != 4'd0)) w_upper_nz = 1'b1;
    end
    w_blank = (r_idx != '0) && !w_upper_nz;
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int PHASE_LEN = scan_div * 125;
  localparam int PH_W      = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

  logic            r_blink_on;
  logic [2:0]      r_blink_phase;
  logic [PH_W-1:0] r_blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_on    <= 1'b0;
      r_blink_phase <= '0;
      r_blink_cnt   <= '0;
    end else if (w_done && (w_bcd != r_shown)) begin
      r_blink_on    <= 1'b1;
      r_blink_phase <= '0;
      r_blink_cnt   <= '0;
    end else if (r_blink_on) begin
      if (r_blink_cnt == PH_W'(PHASE_LEN - 1)) begin
        r_blink_cnt <= '0;
        if (r_blink_phase == 3'd7) r_blink_on <= 1'b0;
        else                       r_blink_phase <= r_blink_phase + 3'd1;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_force_off = r_blink_on && r_blink_phase[0];
`else
  assign w_force_off = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_score <= '0;
      r_shown      <= '0;
      r_scan_cnt   <= '0;
      r_idx        <= '0;
      r_seg        <= SEG_BLANK;
      r_digit      <= '0;
    end else begin
      if (w_start) r_last_score <= score;
      // All digits are replaced in the same cycle, so the display never tears.
      if (w_done)  r_shown <= w_bcd;
      if (r_scan_cnt == SCAN_W'(scan_div - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == IDX_W'(n_show - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_digit <= w_digit'(1) << r_idx;
      r_seg   <= (w_blank || w_force_off) ? SEG_BLANK : seg_of(w_nib);
    end
  end

  assign abcdefgh = r_seg;
  assign digit    = r_digit;

endmodule
